mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port, round-robin arbiter and clear sequencer in front of the 64x8 game-state RAM (`mem`). It lets two requesters share the RAM's single read/write port: the game engine (port A, read/write) and the display scanner (port B, read-only). It drives the RAM's `read_rq`, `write_rq`, `rw_address` and `write_data` pins directly. It also provides a hardware sweep that writes `CLR_VAL` to all 64 locations on game restart.

## Interface
- `AW`, 6: RAM address width; the RAM depth is 2^AW.
- `DW`, 8: RAM data width.
- `CLR_VAL`, 8'h00: value written to every location during a clear sweep.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `clr_req` in 1: start a clear sweep; level-sampled in IDLE.
- `clr_busy` out 1: high while the sweep runs.
- `clr_done` out 1: one-cycle pulse after the last address is written.
- `a_req` in 1: port A request; held until `a_ack`.
- `a_we` in 1: port A operation; 1 = write, 0 = read.
- `a_addr` in AW: port A address.
- `a_wdata` in DW: port A write data.
- `a_ack` out 1: one-cycle completion pulse for port A.
- `a_rdata` out DW: port A read data; valid while `a_ack` is high, held afterwards.
- `b_req` in 1: port B read request; held until `b_ack`.
- `b_addr` in AW: port B address.
- `b_ack` out 1: one-cycle completion pulse for port B.
- `b_rdata` out DW: port B read data; valid while `b_ack` is high, held afterwards.
- `m_read_rq` out 1: to RAM `read_rq`.
- `m_write_rq` out 1: to RAM `write_rq`.
- `m_addr` out AW: to RAM `rw_address`.
- `m_wdata` out DW: to RAM `write_data`.
- `m_rdata` in DW: from RAM `read_data`.

## Operation
- **FSM states:** IDLE, ACC, CLEAR.
- **IDLE, selection priority:** `clr_req` first, then eligible port requests. On selection, register the `m_*` outputs for the next cycle.
  - `clr_req`=1 → CLEAR, with counter = 0.
  - Otherwise, among eligible requesters (a port whose ack is high this cycle is not eligible) → ACC, granting the winner.
  - Nothing eligible → stay in IDLE with `m_read_rq`=`m_write_rq`=0.
- **Round-robin arbitration:**
  - A 1-bit `last` register records the last granted port; its reset value is B.
  - If both ports request, grant the port that is not `last`. A single requester always wins.
  - `last` updates only on an ACC grant; CLEAR does not touch it.
- **ACC (exactly 1 cycle):** the `m_*` outputs are driven from the registered grant.
  - A write: `m_write_rq`=1, `m_read_rq`=0, `m_addr`=`a_addr`, `m_wdata`=`a_wdata`.
  - A read or B read: `m_read_rq`=1, `m_write_rq`=0, address from the granted port, `m_wdata`=0.
  - At the closing edge, reads capture `m_rdata` into the granted port's rdata register. The granted ack is set, and the FSM returns to IDLE.
- **CLEAR:**
  - Each cycle drives `m_write_rq`=1, `m_addr`=counter, `m_wdata`=`CLR_VAL`, and increments the counter.
  - After the cycle with counter = 2^AW-1: `clr_done` pulses for 1 cycle (the IDLE cycle that follows), `clr_busy` drops, and the FSM returns to IDLE.
  - `clr_req` is ignored while in CLEAR. Port requests wait in CLEAR and are not lost.
- **Sampling and stability:** input addresses and data are sampled at the IDLE→ACC edge. The requester must hold `req`, address, data and `we` stable until its ack.
- **`m_read_rq` and `m_write_rq` are never both 1.**

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, `last`=B, clear counter 0, rdata registers 0.
- **Latency:** request seen in IDLE on cycle N → RAM access on cycle N+1 → ack and rdata on cycle N+2.
- **Write visibility:** the write is visible in the RAM from cycle N+2 onward.
- **Throughput:** at most one access per 2 cycles. A request held through its ack cycle is treated as a new request on the following cycle.
- **Clear duration:** 2^AW cycles (64 by default) of CLEAR, then the `clr_done` pulse.
  - A clear starts only from IDLE, so it never splits an ACC.
  - A request arriving during CLEAR is granted at the earliest on the `clr_done` cycle.
- **Reset mid-operation:** asynchronous return to the reset state.
  - An in-flight access produces no ack.
  - A sweep is aborted with no `clr_done` pulse.

## Test plan
- **Write then read on A:** A write addr 5 = 8'hA5, then A read addr 5 → `a_ack` 2 cycles after each request; read returns `a_rdata`=8'hA5.
- **Simultaneous first contention:** A (read addr 1) and B (read addr 2) both assert in the same cycle after reset → A acked first, then B. `m_addr` sequence is 1, then 2.
- **Continuous contention:** A and B both hold `req` continuously → acks alternate A, B, A, B with a 2-cycle spacing. `m_read_rq` and `m_write_rq` are never both high.
- **Clear sweep:** preload addrs 0 and 63 with 8'hFF, pulse `clr_req` → `clr_busy` for 64 cycles, `m_addr` 0..63, `clr_done` pulse. Reads of addrs 0 and 63 then return 8'h00.
- **Request during clear:** `b_req` asserted at CLEAR cycle 10 → no `b_ack` until after `clr_done`; `b_rdata` = `CLR_VAL`.
- **Reset mid-sweep:** assert `rst`=0 at CLEAR cycle 30 → all outputs 0 immediately and no `clr_done`. After release, an A request is acked normally with A winning the first tie.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and clear sequencer for the 64x8 game-state RAM.
// Port A reads/writes, port B reads, and a sweep writes CLR_VAL everywhere.
module mem_arbiter #(
    parameter int                AW      = 6,
    parameter int                DW      = 8,
    parameter logic [DW-1:0]     CLR_VAL = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          m_read_rq,
    output logic          m_write_rq,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        CLEAR
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state, state_nx;
    logic          last, last_nx;
    logic          gnt_b, gnt_b_nx;
    logic [AW-1:0] cnt, cnt_nx;

    logic          rd_nx, wr_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] wdata_nx;
    logic          a_ack_nx, b_ack_nx;
    logic [DW-1:0] a_rdata_nx, b_rdata_nx;
    logic          busy_nx, done_nx;

    logic          a_elig, b_elig, pick_b;

    // A port acked this cycle sits out; on a tie the port not served last wins.
    always_comb begin
        a_elig = a_req & ~a_ack;
        b_elig = b_req & ~b_ack;
        pick_b = b_elig & (~a_elig | ~last);
    end

    // Next-state and next-output decode; every RAM-facing pin is registered.
    always_comb begin
        state_nx   = state;
        last_nx    = last;
        gnt_b_nx   = gnt_b;
        cnt_nx     = cnt;
        rd_nx      = 1'b0;
        wr_nx      = 1'b0;
        addr_nx    = '0;
        wdata_nx   = '0;
        a_ack_nx   = 1'b0;
        b_ack_nx   = 1'b0;
        a_rdata_nx = a_rdata;
        b_rdata_nx = b_rdata;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                    wr_nx    = 1'b1;
                    addr_nx  = '0;
                    wdata_nx = CLR_VAL;
                    busy_nx  = 1'b1;
                end else if (a_elig | b_elig) begin
                    state_nx = ACC;
                    gnt_b_nx = pick_b;
                    last_nx  = pick_b;
                    if (pick_b) begin
                        rd_nx   = 1'b1;
                        addr_nx = b_addr;
                    end else if (a_we) begin
                        wr_nx    = 1'b1;
                        addr_nx  = a_addr;
                        wdata_nx = a_wdata;
                    end else begin
                        rd_nx   = 1'b1;
                        addr_nx = a_addr;
                    end
                end
            end
            ACC: begin
                state_nx = IDLE;
                if (gnt_b) begin
                    b_ack_nx   = 1'b1;
                    b_rdata_nx = m_rdata;
                end else begin
                    a_ack_nx = 1'b1;
                    if (m_read_rq) begin
                        a_rdata_nx = m_rdata;
                    end
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    wr_nx    = 1'b1;
                    addr_nx  = cnt + 1'b1;
                    wdata_nx = CLR_VAL;
                    busy_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, arbitration history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            gnt_b      <= 1'b0;
            cnt        <= '0;
            m_read_rq  <= 1'b0;
            m_write_rq <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            state      <= state_nx;
            last       <= last_nx;
            gnt_b      <= gnt_b_nx;
            cnt        <= cnt_nx;
            m_read_rq  <= rd_nx;
            m_write_rq <= wr_nx;
            m_addr     <= addr_nx;
            m_wdata    <= wdata_nx;
            a_ack      <= a_ack_nx;
            b_ack      <= b_ack_nx;
            a_rdata    <= a_rdata_nx;
            b_rdata    <= b_rdata_nx;
            clr_busy   <= busy_nx;
            clr_done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural RAM and memory model.
// Drivers push expected acks; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam logic [7:0] CLR = 8'h00;

    typedef struct {
        bit         we;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       clr_req;
    logic       clr_busy, clr_done;
    logic       a_req, a_we;
    logic [5:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata;
    logic       b_req;
    logic [5:0] b_addr;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic       m_read_rq, m_write_rq;
    logic [5:0] m_addr;
    logic [7:0] m_wdata, m_rdata;

    logic [7:0] ram [64];
    logic [7:0] init_val [64];
    logic [7:0] ref_mem [64];
    logic       init_en;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t ea, eb;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .AW(6),
        .DW(8),
        .CLR_VAL(CLR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr_req(clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done),
        .a_req(a_req),
        .a_we(a_we),
        .a_addr(a_addr),
        .a_wdata(a_wdata),
        .a_ack(a_ack),
        .a_rdata(a_rdata),
        .b_req(b_req),
        .b_addr(b_addr),
        .b_ack(b_ack),
        .b_rdata(b_rdata),
        .m_read_rq(m_read_rq),
        .m_write_rq(m_write_rq),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val[i];
        end else if (m_write_rq) begin
            ram[m_addr] <= m_wdata;
        end
    end
    assign m_rdata = ram[m_addr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ack and checks timing and data.
    always @(negedge clk) begin
        chk("rw_excl", {31'd0, m_read_rq & m_write_rq}, 32'd0);
        if (a_ack) begin
            if (a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_ack_spurious: got ack expected none at cycle %0d", cyc);
            end else begin
                ea = a_q.pop_front();
                if (ea.cyc >= 0) chk("a_ack_cyc", cyc, ea.cyc);
                if (!ea.we) chk("a_rdata", {24'd0, a_rdata}, {24'd0, ea.data});
            end
        end
        if (b_ack) begin
            if (b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_ack_spurious: got ack expected none at cycle %0d", cyc);
            end else begin
                eb = b_q.pop_front();
                if (eb.cyc >= 0) chk("b_ack_cyc", cyc, eb.cyc);
                chk("b_rdata", {24'd0, b_rdata}, {24'd0, eb.data});
            end
        end
    end

    // Call just after a rising edge; returns just after the edge that
    // follows the ack with the request dropped.
    task automatic a_op(input bit we, input logic [5:0] addr,
                        input logic [7:0] data, input int lat);
        exp_t e;
        bit   got;
        e.we   = we;
        e.data = we ? data : ref_mem[addr];
        e.cyc  = (lat < 0) ? -1 : cyc + lat;
        if (we) ref_mem[addr] = data;
        a_q.push_back(e);
        a_req   = 1'b1;
        a_we    = we;
        a_addr  = addr;
        a_wdata = data;
        got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (a_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL a_timeout: got no ack expected ack for addr %0d", addr);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        a_we  = 1'b0;
    endtask

    task automatic b_op(input logic [5:0] addr, input int lat);
        exp_t e;
        bit   got;
        e.we   = 1'b0;
        e.data = ref_mem[addr];
        e.cyc  = (lat < 0) ? -1 : cyc + lat;
        b_q.push_back(e);
        b_req  = 1'b1;
        b_addr = addr;
        got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (b_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL b_timeout: got no ack expected ack for addr %0d", addr);
        end
        @(posedge clk);
        #1;
        b_req = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        rst     = 1'b0;
        init_en = 1'b1;
        clr_req = 1'b0;
        a_req   = 1'b0;
        a_we    = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        b_req   = 1'b0;
        b_addr  = '0;
        for (int i = 0; i < 64; i++) begin
            init_val[i] = 8'($urandom);
            ref_mem[i]  = init_val[i];
        end
        repeat (3) step();
        init_en = 1'b0;
        chk("rst_ctl", {26'd0, a_ack, b_ack, clr_busy, clr_done,
                        m_read_rq, m_write_rq}, 32'd0);
        chk("rst_maddr", {26'd0, m_addr}, 32'd0);
        chk("rst_mwdata", {24'd0, m_wdata}, 32'd0);
        chk("rst_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // First tie after reset: A first, then B.
        fork
            a_op(1'b0, 6'd1, 8'd0, 2);
            b_op(6'd2, 4);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("tie_addr1", {25'd0, m_read_rq, m_addr}, {25'd0, 1'b1, 6'd1});
                @(negedge clk);
                @(negedge clk);
                chk("tie_addr2", {25'd0, m_read_rq, m_addr}, {25'd0, 1'b1, 6'd2});
            end
        join

        // Continuous contention: acks alternate every 2 cycles.
        fork
            begin
                a_op(1'b0, 6'($urandom_range(0, 63)), 8'd0, 2);
                repeat (3) a_op(1'b0, 6'($urandom_range(0, 63)), 8'd0, 3);
            end
            begin
                b_op(6'($urandom_range(0, 63)), 4);
                repeat (3) b_op(6'($urandom_range(0, 63)), 3);
            end
        join

        // Write then read on A.
        a_op(1'b1, 6'd5, 8'hA5, 2);
        a_op(1'b0, 6'd5, 8'd0, 2);

        // Clear sweep over preloaded ends.
        a_op(1'b1, 6'd0, 8'hFF, 2);
        a_op(1'b1, 6'd63, 8'hFF, 2);
        clr_req = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = CLR;
        step();
        clr_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!(clr_busy && m_write_rq && !m_read_rq && !clr_done &&
                  m_addr == 6'(i) && m_wdata == CLR)) bad++;
        end
        chk("sweep_cycles", bad, 0);
        @(negedge clk);
        chk("clr_done", {30'd0, clr_done, clr_busy}, {30'd0, 2'b10});
        step();
        chk("clr_done_pulse", {31'd0, clr_done}, 32'd0);
        a_op(1'b0, 6'd0, 8'd0, 2);
        a_op(1'b0, 6'd63, 8'd0, 2);

        // B request arriving mid-sweep waits for the done cycle.
        a_op(1'b1, 6'd40, 8'h5A, 2);
        fork
            begin
                clr_req = 1'b1;
                for (int i = 0; i < 64; i++) ref_mem[i] = CLR;
                step();
                clr_req = 1'b0;
            end
            begin
                repeat (10) step();
                b_op(6'd40, 57);
            end
        join

        // Reset in the middle of a sweep.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (29) step();
        chk("mid_busy", {31'd0, clr_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ctl", {26'd0, a_ack, b_ack, clr_busy, clr_done,
                            m_read_rq, m_write_rq}, 32'd0);
        chk("mid_rst_bus", {18'd0, m_addr, m_wdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (70) begin
            @(negedge clk);
            if (clr_done || clr_busy || m_write_rq) bad++;
        end
        chk("no_done_after_abort", bad, 0);
        step();
        fork
            a_op(1'b0, 6'd7, 8'd0, 2);
            b_op(6'd8, 4);
        join

        // Randomised traffic: A owns 0..31, B reads 32..63.
        for (int i = 32; i < 64; i++) a_op(1'b1, 6'(i), 8'($urandom), 2);
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 2)) step();
                    a_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 31)),
                         8'($urandom), -1);
                end
            end
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 2)) step();
                    b_op(6'($urandom_range(32, 63)), -1);
                end
            end
        join
        for (int i = 0; i < 8; i++) begin
            a_op(1'b0, 6'($urandom_range(0, 31)), 8'd0, 2);
        end

        repeat (4) step();
        chk("a_q_empty", a_q.size(), 0);
        chk("b_q_empty", b_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
